// File: rtl/mean_window_pipe.sv
//==============================================================================
// mean_window_pipe : 2-stage boxcar / EMA mean filter, output scaled by 2^WIN_LOG2
// Rev 1.0 -- optional macro MEAN_WINDOW_PREFILL_EN preloads the window on first sample
//==============================================================================
`default_nettype none

module mean_window_pipe #(
  parameter int DATA_WIDTH = 24,
  parameter int WIN_LOG2   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         i_valid,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic [DATA_WIDTH+WIN_LOG2-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_full
);

  localparam int c_ow    = DATA_WIDTH + WIN_LOG2;
  localparam int c_depth = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0]   c_fill_full = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [WIN_LOG2:0]   c_fill_one  = {{WIN_LOG2{1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] c_ptr_one   = {{(WIN_LOG2-1){1'b0}}, 1'b1};
`ifdef MEAN_WINDOW_PREFILL_EN
  localparam logic c_prefill = 1'b1;
`else
  localparam logic c_prefill = 1'b0;
`endif

  // Sample window and its bookkeeping (stage 1 state)
  logic [DATA_WIDTH-1:0] mem_q [c_depth];
  logic [WIN_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WIN_LOG2:0]     fill_q, fill_d;
  logic                  active_q;
  logic                  act_mode_q;

  // Stage 1 pipeline registers
  logic                  s1_valid_q;
  logic                  s1_filt_q;
  logic                  s1_mode_q;
  logic                  s1_first_q;
  logic                  s1_full_q;
  logic                  s1_clr_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [DATA_WIDTH-1:0] s1_old_q;

  // Stage 2 state and outputs
  logic [c_ow-1:0]       sum_q;
  logic [c_ow-1:0]       acc_q;
  logic [c_ow-1:0]       o_data_q;
  logic                  o_valid_q;
  logic                  o_full_q;

  // Stage 1 combinational
  logic                  w_restart;
  logic                  w_flush;
  logic                  w_accept;
  logic                  w_box;
  logic                  w_first;
  logic [WIN_LOG2-1:0]   w_ptr_base;
  logic [WIN_LOG2:0]     w_fill_base;
  logic [DATA_WIDTH-1:0] w_old;

  // A filter restarts when it was idle/flushed, or when mode flips while running.
  always_comb begin
    w_restart   = en && (!active_q || (mode != act_mode_q));
    w_flush     = !en || (active_q && (mode != act_mode_q));
    w_accept    = en && i_valid;
    w_box       = w_accept && !mode;
    w_first     = w_accept && w_restart;
    w_ptr_base  = w_flush ? '0 : wr_ptr_q;
    w_fill_base = w_flush ? '0 : fill_q;
    // Entries not yet written since the last flush count as zero.
    w_old       = (w_fill_base == c_fill_full) ? mem_q[w_ptr_base] : '0;
    wr_ptr_d    = w_ptr_base;
    fill_d      = w_fill_base;
    if (w_box) begin
      if (c_prefill && w_first) begin
        wr_ptr_d = c_ptr_one;
        fill_d   = c_fill_full;
      end else begin
        wr_ptr_d = w_ptr_base + c_ptr_one;
        if (w_fill_base != c_fill_full) begin
          fill_d = w_fill_base + c_fill_one;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_depth; k++) begin
        mem_q[k] <= '0;
      end
    end else if (w_box) begin
      if (c_prefill && w_first) begin
        for (int k = 0; k < c_depth; k++) begin
          mem_q[k] <= i_data;
        end
      end else begin
        mem_q[w_ptr_base] <= i_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      active_q   <= 1'b0;
      act_mode_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_filt_q  <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_full_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_old_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      s1_valid_q <= i_valid;
      s1_filt_q  <= en;
      s1_mode_q  <= mode;
      s1_first_q <= w_first;
      s1_full_q  <= w_box && (fill_d == c_fill_full);
      s1_clr_q   <= w_flush && !w_accept;
      s1_old_q   <= w_old;
      if (i_valid) begin
        s1_data_q <= i_data;
      end
      if (!en) begin
        active_q <= 1'b0;
      end else if (i_valid) begin
        active_q   <= 1'b1;
        act_mode_q <= mode;
      end else if (mode != act_mode_q) begin
        active_q <= 1'b0;
      end
    end
  end

  // Stage 2 combinational
  logic [c_ow-1:0] w_new;
  logic [c_ow-1:0] w_old_ext;
  logic [c_ow-1:0] w_pre;
  logic [c_ow-1:0] w_sum_base;
  logic [c_ow-1:0] w_sum_n;
  logic [c_ow-1:0] w_acc_base;
  logic [c_ow-1:0] w_acc_n;

  always_comb begin
    w_new      = {{WIN_LOG2{1'b0}}, s1_data_q};
    w_old_ext  = {{WIN_LOG2{1'b0}}, s1_old_q};
    w_pre      = {s1_data_q, {WIN_LOG2{1'b0}}};
    w_sum_base = s1_first_q ? '0 : sum_q;
    w_acc_base = s1_first_q ? '0 : acc_q;
    // sum >= oldest entry always holds, so the subtraction never wraps.
    w_sum_n    = (c_prefill && s1_first_q) ? w_pre : (w_sum_base + w_new - w_old_ext);
    w_acc_n    = (c_prefill && s1_first_q) ? w_pre
                                           : (w_acc_base - (w_acc_base >> WIN_LOG2) + w_new);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      acc_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_full_q  <= 1'b0;
    end else begin
      o_valid_q <= s1_valid_q;
      if (s1_valid_q && s1_filt_q) begin
        if (!s1_mode_q) begin
          sum_q    <= w_sum_n;
          acc_q    <= '0;
          o_data_q <= w_sum_n;
          o_full_q <= s1_full_q;
        end else begin
          acc_q    <= w_acc_n;
          sum_q    <= '0;
          o_data_q <= w_acc_n;
          o_full_q <= 1'b0;
        end
      end else if (s1_valid_q) begin
        sum_q    <= '0;
        acc_q    <= '0;
        o_data_q <= w_pre;
        o_full_q <= 1'b0;
      end else if (s1_clr_q) begin
        sum_q    <= '0;
        acc_q    <= '0;
        o_full_q <= 1'b0;
      end
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_full  = o_full_q;

endmodule

`default_nettype wire

// File: doc/mean_window_pipe.md
Name: mean_window_pipe

Overview:
- Next-generation sliding mean filter for the time-grating sample path; sits between the ADC/position front end and the downstream interpolation logic.
- Two selectable modes:
  - true boxcar mean over 2^WIN_LOG2 samples, using a circular sample buffer and a running sum;
  - exponential (first-order IIR) mean with the same scaling.
- Fully pipelined: accepts one sample per clock, fixed 2-cycle latency, bypass when disabled.
- Output is the mean scaled by 2^WIN_LOG2 (no divide), so downstream logic keeps the fractional bits.

Parameters:
- DATA_WIDTH, 24, unsigned input sample width.
- WIN_LOG2, 7, log2 of window length N (boxcar depth N = 2^WIN_LOG2; EMA coefficient 1/N); legal range 1..8.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  filter enable; 0 = bypass and flush
- mode  in  1  0 = boxcar, 1 = EMA
- i_valid  in  1  input sample strobe, one sample per high cycle
- i_data  in  DATA_WIDTH  unsigned sample
- o_data  out  DATA_WIDTH+WIN_LOG2  scaled mean (sum), or bypassed sample
- o_valid  out  1  one-cycle strobe, o_data valid
- o_full  out  1  boxcar window filled (N samples accepted since start)

Behaviour:
- Reset (async, rst=1):
  - o_data=0, o_valid=0, o_full=0;
  - running sum, EMA accumulator, write pointer, fill counter and pipeline registers all 0;
  - buffer contents 0.
- Latency: i_valid at cycle T -> o_valid at T+2, for every sample in both modes and in bypass.
- Back-to-back i_valid is legal every cycle, with no bubbles and no backpressure.
- Stage 1 (cycle T+1):
  - register the sample;
  - boxcar: read the oldest entry buf[wr_ptr], write the new sample to buf[wr_ptr], then wr_ptr <= wr_ptr+1, wrapping modulo N.
- Stage 2 (cycle T+2):
  - boxcar: sum <= sum + new - oldest;
  - EMA: acc <= acc - (acc >> WIN_LOG2) + new;
  - o_data <= the updated sum/acc.
- Width and arithmetic:
  - all arithmetic is unsigned, DATA_WIDTH+WIN_LOG2 bits;
  - sum is bounded by N*(2^DATA_WIDTH-1) and cannot overflow;
  - the EMA acc has the same bound, because its steady state is at most N*max;
  - no rounding: the right shift truncates.
- Fill counter (boxcar only):
  - counts accepted samples, saturating at N;
  - o_full=1 is registered with the o_valid of the Nth sample and stays 1 until flush or reset;
  - in EMA mode o_full=0.
- Before the window is full, the boxcar sum covers only the samples received so far (empty entries read as 0).
- en=0 (bypass):
  - o_data = {sample, WIN_LOG2 zeros} with the same 2-cycle latency and o_valid timing;
  - sum, acc, wr_ptr, fill count and o_full are cleared, and buffer contents are treated as zero on restart.
- en transition:
  - a sample accepted while en=1 completes the filter path even if en drops in the next cycle;
  - samples accepted while en=0 take the bypass path.
- mode change while en=1 performs the same flush as en=0 at that cycle; the sample in that cycle starts the new mode from empty.
- Pipeline state: no state machine beyond the 2-stage valid pipeline plus the filter-active/first-sample flag.

Optional Feature:
- Macro: MEAN_WINDOW_PREFILL_EN.
- Defined: the first sample accepted after reset, flush or mode change preloads the filter as if all N entries held that sample:
  - boxcar: all buffer entries are written with x, sum = x<<WIN_LOG2, and o_full is set immediately;
  - EMA: acc = x<<WIN_LOG2;
  - o_data for that sample is x<<WIN_LOG2.
- Not defined: the filter starts from zero as described above, and o_full asserts only after N samples.

Test Plan (DATA_WIDTH=8, WIN_LOG2=2, no prefill unless stated):
- Boxcar fill: en=1, mode=0, samples 4,8,12,16,20 on consecutive cycles -> o_data 4,12,24,40,56 at T+2..T+6. o_full rises with 40 and stays high.
- EMA step: mode=0->1 flush, then samples 100,100,100 -> o_data 100,175,232 (175>>2=43 truncated).
- Max value: 255 x6 in boxcar -> o_data settles to 1020 (0x3FC), with no wrap.
- Bypass and latency: en=0, i_data=0xAB for one cycle -> o_valid exactly 2 cycles later, o_data=0x2AC, o_full=0. Re-enabling and sending 4 gives o_data 4.
- Reset mid-stream: after 3 boxcar samples, pulse rst asynchronously between clock edges -> outputs 0 immediately. The next sample 8 gives o_data 8.
- MEAN_WINDOW_PREFILL_EN defined: first sample 10 -> o_data 40 with o_full=1. Then sample 14 -> 44 (boxcar), or 44 (EMA: 40-10+14).
